// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants, MEM/WB register layout and memory-access helpers.
package mips_pkg;

    localparam int unsigned DATA_W     = 32;
    localparam int unsigned REG_ADDR_W = 5;

    typedef logic [1:0] mem_size_t;

    localparam mem_size_t MEM_WORD = 2'b00;
    localparam mem_size_t MEM_HALF = 2'b01;
    localparam mem_size_t MEM_BYTE = 2'b10;

    typedef struct packed {
        logic [DATA_W-1:0]     alu;
        logic [REG_ADDR_W-1:0] rdst;
        logic                  mem_to_reg;
        logic                  reg_write;
        logic                  mem_read;
        logic                  sign_ext;
        logic                  fault;
        mem_size_t             size;
        logic [1:0]            lane;
    } mem_wb_t;

    // Size encoding 2'b11 falls into the word case.
    function automatic logic is_misaligned(mem_size_t size, logic [1:0] lane);
        case (size)
            MEM_BYTE: return 1'b0;
            MEM_HALF: return lane[0];
            default:  return lane != 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(mem_size_t size, logic [1:0] lane);
        case (size)
            MEM_BYTE: return 4'b0001 << lane;
            MEM_HALF: return lane[1] ? 4'b1100 : 4'b0011;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, pipeline control and MEM/WB outputs of the MEM stage.
interface mem_stage_if;
    import mips_pkg::*;

    logic                  Stall;
    logic                  Flush;
    logic [DATA_W-1:0]     ex_memALUResult;
    logic [DATA_W-1:0]     ex_memWriteData;
    logic [REG_ADDR_W-1:0] ex_memRegDstop;
    logic                  ex_memMemRead;
    logic                  ex_memMemWrite;
    logic                  ex_memMemToReg;
    logic                  ex_memRegWrite;
    logic [1:0]            ex_memMemSize;
    logic                  ex_memMemSigned;
    logic [DATA_W-1:0]     mem_wbReadData;
    logic [DATA_W-1:0]     mem_wbALUResult;
    logic [REG_ADDR_W-1:0] mem_wbRegDstop;
    logic                  mem_wbMemToReg;
    logic                  mem_wbRegWrite;
    logic [DATA_W-1:0]     WriteDataip;
    logic                  MisalignFault;

    modport master (
        output Stall, Flush, ex_memALUResult, ex_memWriteData, ex_memRegDstop, ex_memMemRead,
               ex_memMemWrite, ex_memMemToReg, ex_memRegWrite, ex_memMemSize, ex_memMemSigned,
        input  mem_wbReadData, mem_wbALUResult, mem_wbRegDstop, mem_wbMemToReg, mem_wbRegWrite,
               WriteDataip, MisalignFault
    );

    modport slave (
        input  Stall, Flush, ex_memALUResult, ex_memWriteData, ex_memRegDstop, ex_memMemRead,
               ex_memMemWrite, ex_memMemToReg, ex_memRegWrite, ex_memMemSize, ex_memMemSigned,
        output mem_wbReadData, mem_wbALUResult, mem_wbRegDstop, mem_wbMemToReg, mem_wbRegWrite,
               WriteDataip, MisalignFault
    );

endinterface

// File: rtl/data_memory.sv
// Word-organised data RAM: synchronous read of the pre-write word, byte-enabled write.
module data_memory #(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic                           clk_i,
    input  logic                           re_i,
    input  logic                           we_i,
    input  logic [3:0]                     be_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
        if (we_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: data memory access, lane alignment/extension, MEM/WB register, writeback mux.
module mem_stage
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input logic        Clk,
    input logic        Rst,
    mem_stage_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    logic [1:0]        lane;
    mem_size_t         size;
    logic              misalign;
    logic              advance;
    logic              store_en;
    logic [AW-1:0]     word_addr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] rdata_shifted;
    logic [15:0]       rdata_half;
    logic [DATA_W-1:0] load_data;
    logic              unused_addr;
    mem_wb_t           mem_wb_d, mem_wb_q;

    assign lane        = bus.ex_memALUResult[1:0];
    assign size        = bus.ex_memMemSize;
    assign word_addr   = bus.ex_memALUResult[AW+1:2];
    assign unused_addr = ^bus.ex_memALUResult[DATA_W-1:AW+2];
    assign misalign    = (bus.ex_memMemRead | bus.ex_memMemWrite) & is_misaligned(size, lane);
    assign advance     = ~bus.Stall & ~bus.Flush;
    // Gating with Rst keeps a store from landing on an edge where reset is held.
    assign store_en    = Rst & advance & bus.ex_memMemWrite & ~misalign;
    assign be          = byte_enables(size, lane);

    always_comb begin
        case (size)
            MEM_BYTE: wdata = {4{bus.ex_memWriteData[7:0]}};
            MEM_HALF: wdata = {2{bus.ex_memWriteData[15:0]}};
            default:  wdata = bus.ex_memWriteData;
        endcase
    end

    // Read enable follows advance so a stalled stage keeps its fetched word.
    data_memory #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_dmem (
        .clk_i  (Clk),
        .re_i   (advance),
        .we_i   (store_en),
        .be_i   (be),
        .addr_i (word_addr),
        .wdata_i(wdata),
        .rdata_o(rdata)
    );

    always_comb begin
        mem_wb_d = mem_wb_q;
        if (bus.Flush) begin
            mem_wb_d = '0;
        end else if (bus.Stall) begin
            mem_wb_d.fault = 1'b0;
        end else begin
            mem_wb_d.alu        = bus.ex_memALUResult;
            mem_wb_d.rdst       = bus.ex_memRegDstop;
            mem_wb_d.mem_to_reg = bus.ex_memMemToReg;
            mem_wb_d.reg_write  = bus.ex_memRegWrite & ~misalign;
            mem_wb_d.mem_read   = bus.ex_memMemRead;
            mem_wb_d.sign_ext   = bus.ex_memMemSigned;
            mem_wb_d.fault      = misalign;
            mem_wb_d.size       = size;
            mem_wb_d.lane       = lane;
        end
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            mem_wb_q <= '0;
        end else begin
            mem_wb_q <= mem_wb_d;
        end
    end

    assign rdata_shifted = rdata >> {mem_wb_q.lane, 3'b000};
    assign rdata_half    = mem_wb_q.lane[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        load_data = '0;
        if (mem_wb_q.mem_read) begin
            case (mem_wb_q.size)
                MEM_BYTE: load_data = {{24{mem_wb_q.sign_ext & rdata_shifted[7]}},
                                       rdata_shifted[7:0]};
                MEM_HALF: load_data = {{16{mem_wb_q.sign_ext & rdata_half[15]}}, rdata_half};
                default:  load_data = rdata;
            endcase
        end
    end

    assign bus.mem_wbReadData  = load_data;
    assign bus.mem_wbALUResult = mem_wb_q.alu;
    assign bus.mem_wbRegDstop  = mem_wb_q.rdst;
    assign bus.mem_wbMemToReg  = mem_wb_q.mem_to_reg;
    assign bus.mem_wbRegWrite  = mem_wb_q.reg_write;
    assign bus.MisalignFault   = mem_wb_q.fault;
    assign bus.WriteDataip     = mem_wb_q.mem_to_reg ? load_data : mem_wb_q.alu;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, corner sequences, randomized model check.
module tb_mem_stage;
    import mips_pkg::*;

    localparam int unsigned DEPTH = 1024;
    localparam int unsigned BYTES = 4 * DEPTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_stage_if bus ();

    mem_stage #(
        .DEPTH_WORDS(DEPTH)
    ) dut (
        .Clk(clk),
        .Rst(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Byte-addressed reference memory and the expected MEM/WB view.
    logic [7:0]  mref [BYTES];
    logic [31:0] e_rdata, e_alu;
    logic [4:0]  e_rdst;
    logic        e_m2r, e_rw, e_fault, e_rdc;

    typedef struct {
        bit          wr, rd, m2r, rw;
        logic [1:0]  sz;
        bit          sgn;
        logic [31:0] a, d;
        logic [31:0] x_rdata, x_wd;
        bit          x_rw, x_fault;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit wr, input bit rd, input bit m2r, input bit rw,
                         input logic [1:0] sz, input bit sgn, input logic [31:0] a,
                         input logic [31:0] d, input logic [4:0] rdst,
                         input bit stall, input bit flush);
        bus.ex_memMemWrite  = wr;
        bus.ex_memMemRead   = rd;
        bus.ex_memMemToReg  = m2r;
        bus.ex_memRegWrite  = rw;
        bus.ex_memMemSize   = sz;
        bus.ex_memMemSigned = sgn;
        bus.ex_memALUResult = a;
        bus.ex_memWriteData = d;
        bus.ex_memRegDstop  = rdst;
        bus.Stall           = stall;
        bus.Flush           = flush;
    endtask

    task automatic model_zero();
        e_rdata = '0; e_alu = '0; e_rdst = '0;
        e_m2r = 0; e_rw = 0; e_fault = 0; e_rdc = 0;
    endtask

    // Applies the stage's effect of the inputs present at the edge just taken.
    task automatic model_edge();
        int n, ba;
        bit mis;
        logic [31:0] v;
        if (!rst_n || bus.Flush) begin
            model_zero();
            return;
        end
        if (bus.Stall) begin
            e_fault = 0;
            return;
        end
        ba  = int'(bus.ex_memALUResult % BYTES);
        n   = (bus.ex_memMemSize == MEM_BYTE) ? 1 : (bus.ex_memMemSize == MEM_HALF) ? 2 : 4;
        mis = (bus.ex_memMemRead || bus.ex_memMemWrite) && (ba % n != 0);
        v   = '0;
        for (int i = 0; i < n; i++) v |= 32'(mref[(ba + i) % BYTES]) << (8 * i);
        if (bus.ex_memMemSigned && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        e_rdata = bus.ex_memMemRead ? v : 32'h0;
        e_rdc   = bus.ex_memMemRead && mis;
        if (bus.ex_memMemWrite && !mis)
            for (int i = 0; i < n; i++) mref[ba + i] = bus.ex_memWriteData[8*i +: 8];
        e_alu   = bus.ex_memALUResult;
        e_rdst  = bus.ex_memRegDstop;
        e_m2r   = bus.ex_memMemToReg;
        e_rw    = bus.ex_memRegWrite && !mis;
        e_fault = mis;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_alu"}, bus.mem_wbALUResult, e_alu);
        check({tag, "_ctl"}, {24'b0, bus.mem_wbRegDstop, bus.mem_wbMemToReg, bus.mem_wbRegWrite,
                              bus.MisalignFault}, {24'b0, e_rdst, e_m2r, e_rw, e_fault});
        if (!e_rdc) begin
            check({tag, "_rdata"}, bus.mem_wbReadData, e_rdata);
            check({tag, "_wd"}, bus.WriteDataip, e_m2r ? e_rdata : e_alu);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra;
        model_zero();
        drive(0, 0, 0, 0, MEM_WORD, 0, 32'h0, 32'h0, 5'd0, 0, 0);
        #12;
        check("reset_wd", bus.WriteDataip, 32'h0);
        check("reset_ctl", {bus.mem_wbReadData[26:0], bus.mem_wbRegDstop},
              {27'h0, 5'h0});
        check("reset_flags", {29'b0, bus.mem_wbMemToReg, bus.mem_wbRegWrite, bus.MisalignFault},
              32'h0);
        rst_n = 1'b1;

        for (int w = 0; w < 16; w++) begin
            drive(1, 0, 0, 0, MEM_WORD, 0, 32'(w * 4), 32'h0, 5'd0, 0, 0);
            step();
        end

        tbl.push_back(vec_t'{1, 0, 0, 0, MEM_WORD, 0, 32'h10, 32'hDEADBEEF, 32'h0, 32'h10, 0, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, MEM_WORD, 0, 32'h10, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF, 1, 0});
        tbl.push_back(vec_t'{1, 0, 0, 0, MEM_BYTE, 0, 32'h21, 32'h7F, 32'h0, 32'h21, 0, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, MEM_BYTE, 1, 32'h21, 32'h0, 32'h7F, 32'h7F, 1, 0});
        tbl.push_back(vec_t'{1, 0, 0, 0, MEM_BYTE, 0, 32'h22, 32'h80, 32'h0, 32'h22, 0, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, MEM_BYTE, 1, 32'h22, 32'h0, 32'hFFFFFF80, 32'hFFFFFF80, 1, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, MEM_BYTE, 0, 32'h22, 32'h0, 32'h80, 32'h80, 1, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, MEM_WORD, 0, 32'h20, 32'h0, 32'h00807F00, 32'h00807F00, 1, 0});
        tbl.push_back(vec_t'{1, 0, 0, 0, MEM_WORD, 0, 32'h30, 32'h11223344, 32'h0, 32'h30, 0, 0});
        tbl.push_back(vec_t'{1, 0, 0, 1, MEM_HALF, 0, 32'h31, 32'hBEEF, 32'h0, 32'h31, 0, 1});
        tbl.push_back(vec_t'{0, 1, 1, 1, MEM_WORD, 0, 32'h30, 32'h0, 32'h11223344, 32'h11223344, 1, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, MEM_HALF, 1, 32'h12, 32'h0, 32'hFFFFDEAD, 32'hFFFFDEAD, 1, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, MEM_HALF, 0, 32'h32, 32'h0, 32'h1122, 32'h1122, 1, 0});
        tbl.push_back(vec_t'{1, 0, 0, 0, MEM_WORD, 0, 32'h1008, 32'hCAFEF00D, 32'h0, 32'h1008, 0, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, MEM_WORD, 0, 32'h8, 32'h0, 32'hCAFEF00D, 32'hCAFEF00D, 1, 0});
        tbl.push_back(vec_t'{1, 0, 0, 0, MEM_HALF, 0, 32'h12, 32'hBEEF, 32'h0, 32'h12, 0, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, 2'b11, 0, 32'h10, 32'h0, 32'hBEEFBEEF, 32'hBEEFBEEF, 1, 0});
        tbl.push_back(vec_t'{1, 1, 1, 1, MEM_WORD, 0, 32'h10, 32'h55667788, 32'hBEEFBEEF, 32'hBEEFBEEF, 1, 0});
        tbl.push_back(vec_t'{0, 1, 1, 1, MEM_WORD, 0, 32'h10, 32'h0, 32'h55667788, 32'h55667788, 1, 0});
        tbl.push_back(vec_t'{0, 1, 0, 1, MEM_BYTE, 1, 32'h13, 32'h0, 32'h55, 32'h13, 1, 0});

        foreach (tbl[i]) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].m2r, tbl[i].rw, tbl[i].sz, tbl[i].sgn, tbl[i].a,
                  tbl[i].d, 5'(i + 1), 0, 0);
            step();
            check($sformatf("vec%0d_rdata", i), bus.mem_wbReadData, tbl[i].x_rdata);
            check($sformatf("vec%0d_wd", i), bus.WriteDataip, tbl[i].x_wd);
            check($sformatf("vec%0d_ctl", i), {24'b0, bus.mem_wbRegDstop, 1'b0, bus.mem_wbRegWrite,
                  bus.MisalignFault}, {24'b0, 5'(i + 1), 1'b0, tbl[i].x_rw, tbl[i].x_fault});
        end

        // Stall holds MEM/WB and blocks the store; Flush wins over Stall.
        drive(0, 0, 0, 1, MEM_WORD, 0, 32'h1234, 32'h0, 5'd7, 0, 0);
        step();
        check("rtype_wd", bus.WriteDataip, 32'h1234);
        for (int k = 0; k < 2; k++) begin
            drive(1, 0, 0, 0, MEM_WORD, 0, 32'h3C, 32'hA5A5A5A5, 5'd9, 1, 0);
            step();
            check($sformatf("stall%0d_alu", k), bus.mem_wbALUResult, 32'h1234);
            check($sformatf("stall%0d_ctl", k), {27'b0, bus.mem_wbRegDstop},
                  {27'b0, 5'd7} | 32'(bus.mem_wbRegWrite ? 0 : 32'h100));
        end
        drive(1, 0, 1, 1, MEM_WORD, 0, 32'h3C, 32'hA5A5A5A5, 5'd9, 1, 1);
        step();
        check("flush_ctl", {30'b0, bus.mem_wbRegWrite, bus.mem_wbMemToReg}, 32'h0);
        check("flush_wd", bus.WriteDataip, 32'h0);
        drive(0, 1, 1, 1, MEM_WORD, 0, 32'h3C, 32'h0, 5'd4, 0, 0);
        step();
        check("nostore_rdata", bus.WriteDataip, 32'h0);

        // Fault pulse lasts one cycle and is silent under Stall and Flush.
        drive(0, 1, 1, 1, MEM_WORD, 0, 32'h3E, 32'h0, 5'd4, 0, 0);
        step();
        check("mis_fault", {30'b0, bus.MisalignFault, bus.mem_wbRegWrite}, 32'h2);
        drive(0, 1, 1, 1, MEM_WORD, 0, 32'h3E, 32'h0, 5'd4, 1, 0);
        step();
        check("mis_stall_fault", {31'b0, bus.MisalignFault}, 32'h0);
        drive(0, 1, 1, 1, MEM_WORD, 0, 32'h3E, 32'h0, 5'd4, 0, 1);
        step();
        check("mis_flush_fault", {31'b0, bus.MisalignFault}, 32'h0);

        // Asynchronous reset in the middle of a store cycle.
        drive(0, 0, 0, 1, MEM_WORD, 0, 32'h77, 32'h0, 5'd3, 0, 0);
        step();
        check("pre_rst_wd", bus.WriteDataip, 32'h77);
        drive(1, 0, 0, 0, MEM_WORD, 0, 32'h3C, 32'hA5A5A5A5, 5'd2, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_wd", bus.WriteDataip, 32'h0);
        check("arst_ctl", {24'b0, bus.mem_wbRegDstop, bus.mem_wbMemToReg, bus.mem_wbRegWrite,
              bus.MisalignFault}, 32'h0);
        check("arst_alu", bus.mem_wbALUResult, 32'h0);
        step();
        drive(0, 1, 1, 1, MEM_WORD, 0, 32'h3C, 32'h0, 5'd2, 0, 0);
        #2;
        rst_n = 1'b1;
        step();
        check("arst_mem_kept", bus.mem_wbReadData, 32'h0);

        // Randomized traffic over words 0..15 with random upper address bits.
        for (int c = 0; c < 400; c++) begin
            ra = $urandom & 32'hFFFF_F03F;
            if ($urandom_range(1) == 0) ra[1:0] = 2'b00;
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  2'($urandom_range(3)), 1'($urandom), ra, $urandom, 5'($urandom),
                  $urandom_range(7) == 0, $urandom_range(9) == 0);
            step();
            check_model("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
